// File: rtl/serial_subtractor.sv
// Bit-serial N-bit unsigned subtractor: D = (A - B) mod 2^N and borrow-out, LSB first, one bit per clock.
// Optional macro SERIAL_SUB_OVF_EN adds the registered signed-overflow output V.
module serial_subtractor #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] D,
    output logic         BO
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         V
`endif
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [N-1:0]  a_sh;
    logic [N-1:0]  b_sh;
    logic [N-1:0]  res_sh;
    logic [N-1:0]  res_nxt;
    logic          borrow;
    logic [CW-1:0] cnt;

    logic a_i, b_i, d_i, bout;
    logic accept, last;

    // Full-subtractor cell: returns {borrow_out, difference}.
    function automatic logic [1:0] fsub(input logic a, input logic b, input logic bin);
        logic d, bo;
        d  = a ^ b ^ bin;
        bo = (~a & b) | (~(a ^ b) & bin);
        return {bo, d};
    endfunction

    assign a_i            = a_sh[0];
    assign b_i            = b_sh[0];
    assign {bout, d_i}    = fsub(a_i, b_i, borrow);
    assign res_nxt        = {d_i, res_sh[N-1:1]};
    assign last           = (cnt == CW'(N - 1));
    assign accept         = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, serial bit processing, and result registers loaded on the final bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            D      <= '0;
            BO     <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            V      <= 1'b0;
`endif
        end else if (accept) begin
            a_sh   <= A;
            b_sh   <= B;
            res_sh <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_nxt;
            borrow <= bout;
            cnt    <= cnt + CW'(1);
            if (last) begin
                D  <= res_nxt;
                BO <= bout;
`ifdef SERIAL_SUB_OVF_EN
                // On the final bit a_i/b_i are the operand sign bits and d_i is the result sign.
                V  <= (a_i != b_i) && (d_i != a_i);
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed boundary cases, backpressure, async reset abort, random traffic.
module tb_serial_subtractor;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] D;
    logic         BO;
`ifdef SERIAL_SUB_OVF_EN
    logic         V;
`endif

    serial_subtractor #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .BO        (BO)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .V         (V)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] d;
        logic         bo;
        logic         v;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        e.d  = a - b;
        e.bo = (a < b);
        e.v  = (a[N-1] != b[N-1]) && (e.d[N-1] != a[N-1]);
        return e;
    endfunction

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
        end else begin
            e = sb.pop_front();
            check("D", D, e.d);
            check("BO", BO, e.bo);
`ifdef SERIAL_SUB_OVF_EN
            check("V", V, e.v);
`endif
        end
    endtask

    // Returns at the falling edge right after the accept edge.
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b);
        int g = 0;
        @(negedge clk);
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            check("send_timeout", 0, 1);
        end else begin
            A        = a;
            B        = b;
            in_valid = 1'b1;
            sb.push_back(model(a, b));
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic recv(input bit chk_lat);
        int lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (chk_lat) check("latency", lat, N);
        if (!out_valid) begin
            check("recv_timeout", 0, 1);
        end else begin
            compare_out();
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check("valid_drop", out_valid, 0);
        end
    endtask

    initial begin
        int g;
        int sent;
        int got;
        int cyc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_D", D, 0);
        check("rst_BO", BO, 0);
        rst = 1'b0;

        send(4'd7, 4'd3);
        recv(1'b1);
        send(4'd3, 4'd7);
        recv(1'b0);

        // Abort A=5,B=9 after two bits; D/BO still hold 12/1 from the previous result.
        @(negedge clk);
        A        = 4'd5;
        B        = 4'd9;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("run_in_ready", in_ready, 0);
        check("run_D_hold", D, 12);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_D", D, 0);
        check("arst_BO", BO, 0);
        @(negedge clk);
        rst = 1'b0;
        send(4'd9, 4'd5);
        recv(1'b0);

        send(4'd8, 4'd1);
        recv(1'b0);
        send(4'd0, 4'd0);
        recv(1'b0);
        send(4'd0, 4'd1);
        recv(1'b0);
        send(4'd11, 4'd0);
        recv(1'b0);

        // Backpressure with an ignored in_valid pulse.
        send(4'd15, 4'd15);
        g = 0;
        while (!out_valid && g < 100) begin
            @(negedge clk);
            g++;
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                A        = 4'd1;
                B        = 4'd0;
                in_valid = 1'b1;
            end
            if (i == 6) in_valid = 1'b0;
            check("bp_valid", out_valid, 1);
            check("bp_D", D, 0);
            check("bp_BO", BO, 0);
            check("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        recv(1'b0);
        repeat (N + 3) @(negedge clk);
        check("bp_no_extra", out_valid, 0);

        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < 1000 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            A         = N'($urandom_range(0, (1 << N) - 1));
            B         = N'($urandom_range(0, (1 << N) - 1));
            out_ready = ($urandom_range(0, 1) != 0);
            if (in_valid && in_ready) begin
                sb.push_back(model(A, B));
                sent++;
            end
            if (out_valid && out_ready) begin
                compare_out();
                got++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("rand_count", got, 1000);
        check("sb_left", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
